resim_cozucu: RTL

Reconstructs 3-bit raw pixels from a stream of 5-bit filtered image words, the inverse end of the image filter path. Accepts words over a valid/ready handshake, classifies each word, and regenerates pixels into a 2-entry output buffer. Tracks frame length and end-of-frame markers, and raises a sticky error on protocol violations. Sits between the filtered-image transport and the pixel consumer.

---
 rtl/resim_cozucu.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/resim_cozucu.sv
// resim_cozucu: rebuilds 3-bit raw pixels from 5-bit filtered image words.
// Words arrive over valid/ready, are classified (pixel, repeat, end-of-frame,
// illegal), and reconstructed pixels leave through a 2-entry output buffer
// tagged with an end-of-frame flag. Protocol violations raise a sticky error.
//
// Optional feature macro: RESIM_COZUCU_TEKRAR_EN
//   defined   : word 10000 repeats the last pixel (last-pixel register present)
//   undefined : word 10000 is illegal (dropped, raises the error flag)
module resim_cozucu #(
  parameter int CERCEVE_PIKSEL = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [4:0]                        filtrelenmis_resim,
  input  logic                              giris_gecerli,
  output logic                              giris_hazir,
  output logic [2:0]                        saf_resim,
  output logic                              cerceve_son,
  output logic                              cikis_gecerli,
  input  logic                              cikis_hazir,
  output logic                              hata,
  input  logic                              hata_temizle,
  output logic [$clog2(CERCEVE_PIKSEL)-1:0] piksel_sayisi
);

  localparam int SW = $clog2(CERCEVE_PIKSEL);
  // Frame length in a width one bit wider than the counter so a
  // power-of-two length can be compared without overflow.
  localparam logic [SW:0]   SON_SAYI   = (SW+1)'(CERCEVE_PIKSEL);
  localparam logic [SW-1:0] SAYAC_SIFIR = SW'(32'd0);
  localparam logic [SW-1:0] SAYAC_BIR   = SW'(32'd1);

  typedef enum logic [0:0] {
    VERI_AL   = 1'b0,
    SON_BEKLE = 1'b1
  } durum_t;

  durum_t        durum_r;
  logic [SW-1:0] sayac_r;
  logic          hata_r;

  // Output buffer: slot 0 is the head shown to the consumer.
  logic          dolu0_r;
  logic          dolu1_r;
  logic [2:0]    bas_piksel_r;
  logic          bas_son_r;
  logic [2:0]    ikinci_piksel_r;
  logic          ikinci_son_r;

  logic          kabul_s;
  logic          cikar_s;
  logic          veri_s;
  logic          tekrar_s;
  logic          son_kelime_s;
  logic          piksel_kelime_s;
  logic [2:0]    piksel_deger_s;
  logic          cerceve_tamam_s;
  logic          ekle_s;
  logic          ekle_son_s;
  logic          hata_olay_s;

  // Ready depends only on registered occupancy: room exists unless slot 1 is full.
  assign giris_hazir   = ~dolu1_r;
  assign kabul_s       = giris_gecerli & giris_hazir;
  assign cikar_s       = dolu0_r & cikis_hazir;

  assign cikis_gecerli = dolu0_r;
  assign saf_resim     = bas_piksel_r;
  assign cerceve_son   = bas_son_r;
  assign hata          = hata_r;
  assign piksel_sayisi = sayac_r;

  assign veri_s       = ~filtrelenmis_resim[4] & ~filtrelenmis_resim[0];
  assign son_kelime_s = (filtrelenmis_resim == 5'b10001);

`ifdef RESIM_COZUCU_TEKRAR_EN
  logic [2:0] son_piksel_r;

  assign tekrar_s       = (filtrelenmis_resim == 5'b10000);
  assign piksel_deger_s = veri_s ? filtrelenmis_resim[3:1] : son_piksel_r;

  // Last-pixel register: follows data words, cleared after a repeat is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      son_piksel_r <= 3'd0;
    end else if (kabul_s && veri_s) begin
      son_piksel_r <= filtrelenmis_resim[3:1];
    end else if (kabul_s && tekrar_s) begin
      son_piksel_r <= 3'd0;
    end else begin
      son_piksel_r <= son_piksel_r;
    end
  end
`else
  assign tekrar_s       = 1'b0;
  assign piksel_deger_s = filtrelenmis_resim[3:1];
`endif

  assign piksel_kelime_s = veri_s | tekrar_s;
  assign cerceve_tamam_s = (({1'b0, sayac_r} + {SAYAC_SIFIR, 1'b1}) == SON_SAYI);

  // Decode of the accepted word: what gets pushed and whether it is an error.
  always_comb begin
    ekle_s      = 1'b0;
    ekle_son_s  = 1'b0;
    hata_olay_s = 1'b0;
    if (kabul_s) begin
      if (piksel_kelime_s) begin
        ekle_s = 1'b1;
        case (durum_r)
          VERI_AL:   ekle_son_s  = cerceve_tamam_s;
          SON_BEKLE: hata_olay_s = 1'b1;
          default:   hata_olay_s = 1'b1;
        endcase
      end else if (son_kelime_s) begin
        case (durum_r)
          VERI_AL:   hata_olay_s = (sayac_r != SAYAC_SIFIR);
          SON_BEKLE: hata_olay_s = 1'b0;
          default:   hata_olay_s = 1'b1;
        endcase
      end else begin
        hata_olay_s = 1'b1;
      end
    end else begin
      ekle_s = 1'b0;
    end
  end

  // Frame FSM and pixel counter; illegal words leave both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_r <= VERI_AL;
      sayac_r <= SAYAC_SIFIR;
    end else if (kabul_s && piksel_kelime_s) begin
      case (durum_r)
        VERI_AL: begin
          if (cerceve_tamam_s) begin
            sayac_r <= SAYAC_SIFIR;
            durum_r <= SON_BEKLE;
          end else begin
            sayac_r <= sayac_r + SAYAC_BIR;
          end
        end
        SON_BEKLE: begin
          // Missing end marker: this pixel starts the next frame.
          sayac_r <= SAYAC_BIR;
          durum_r <= VERI_AL;
        end
        default: begin
          sayac_r <= SAYAC_SIFIR;
          durum_r <= VERI_AL;
        end
      endcase
    end else if (kabul_s && son_kelime_s) begin
      case (durum_r)
        VERI_AL:   sayac_r <= SAYAC_SIFIR;
        SON_BEKLE: durum_r <= VERI_AL;
        default: begin
          sayac_r <= SAYAC_SIFIR;
          durum_r <= VERI_AL;
        end
      endcase
    end
  end

  // Sticky error: a new error in the clear cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hata_r <= 1'b0;
    end else if (hata_olay_s) begin
      hata_r <= 1'b1;
    end else if (hata_temizle) begin
      hata_r <= 1'b0;
    end
  end

  // Two-slot shifting output buffer; push never happens when both slots are full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dolu0_r         <= 1'b0;
      dolu1_r         <= 1'b0;
      bas_piksel_r    <= 3'd0;
      bas_son_r       <= 1'b0;
      ikinci_piksel_r <= 3'd0;
      ikinci_son_r    <= 1'b0;
    end else begin
      case ({ekle_s, cikar_s})
        2'b10: begin
          if (!dolu0_r) begin
            bas_piksel_r <= piksel_deger_s;
            bas_son_r    <= ekle_son_s;
            dolu0_r      <= 1'b1;
          end else begin
            ikinci_piksel_r <= piksel_deger_s;
            ikinci_son_r    <= ekle_son_s;
            dolu1_r         <= 1'b1;
          end
        end
        2'b01: begin
          if (dolu1_r) begin
            bas_piksel_r <= ikinci_piksel_r;
            bas_son_r    <= ikinci_son_r;
          end
          dolu0_r <= dolu1_r;
          dolu1_r <= 1'b0;
        end
        2'b11: begin
          if (dolu1_r) begin
            bas_piksel_r    <= ikinci_piksel_r;
            bas_son_r       <= ikinci_son_r;
            ikinci_piksel_r <= piksel_deger_s;
            ikinci_son_r    <= ekle_son_s;
          end else begin
            bas_piksel_r <= piksel_deger_s;
            bas_son_r    <= ekle_son_s;
          end
        end
        default: begin
          dolu0_r <= dolu0_r;
          dolu1_r <= dolu1_r;
        end
      endcase
    end
  end

endmodule
